// File: rtl/piece_mover_pkg.sv
// Shared definitions for the falling-piece mover: FSM encoding, board size and edge masks.
// Board row r sits in bits [4r+3:4r]; row 0 is the top and row 7 is the bottom.
package piece_mover_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 4;

  typedef enum logic [2:0] {
    GEN  = 3'd0,
    FALL = 3'd1,
    LOCK = 3'd2,
    OVER = 3'd3
  } state_t;

  localparam logic [31:0] COL0_MASK = 32'h1111_1111;
  localparam logic [31:0] COL3_MASK = 32'h8888_8888;
  localparam logic [31:0] ROW7_MASK = 32'hF000_0000;

endpackage

// File: rtl/piece_collide.sv
// Combinational collision check of a candidate piece against the stack and the board edges.
// Zero latency, no flow control.
module piece_collide
  import piece_mover_pkg::*;
#(
  parameter int W = ROWS * COLS
) (
  input  logic [W-1:0] stack,
  input  logic [W-1:0] cand,
  output logic         overlap,
  output logic         hit_left,
  output logic         hit_right,
  output logic         hit_bottom
);

  assign overlap    = |(stack & cand);
  assign hit_left   = |(cand & COL0_MASK);
  assign hit_right  = |(cand & COL3_MASK);
  assign hit_bottom = |(cand & ROW7_MASK);

endmodule

// File: rtl/piece_mover.sv
// Moves one falling piece over a settled stack: spawn, lateral moves, gravity ticks, lock.
// Accepted moves/ticks show on board_out one cycle later; requests outside their state are dropped.
module piece_mover #(
  parameter int ROWS = piece_mover_pkg::ROWS,
  parameter int COLS = piece_mover_pkg::COLS
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 spawn,
  input  logic [ROWS*COLS-1:0] board_in,
  input  logic [ROWS*COLS-1:0] piece_in,
  input  logic                 move_left,
  input  logic                 move_right,
  input  logic                 tick,
  output logic [ROWS*COLS-1:0] board_out,
  output logic [2:0]           state,
  output logic                 landed,
  output logic                 error
);
  import piece_mover_pkg::*;

  localparam int W = ROWS * COLS;

  state_t         state_q, state_d;
  logic [W-1:0]   stack_q, stack_d;
  logic [W-1:0]   piece_q, piece_d;
  logic           error_q, error_d;
  logic [W-1:0]   pos;

  logic cur_left, cur_right, left_ovl, right_ovl, pos_bottom, down_ovl;
  logic cur_ovl_n, cur_bot_n, l_l_n, l_r_n, l_b_n, r_l_n, r_r_n, r_b_n;
  logic p_ovl_n, p_l_n, p_r_n, d_l_n, d_r_n, d_b_n;

  piece_collide #(.W(W)) u_cur (
    .stack(stack_q), .cand(piece_q),
    .overlap(cur_ovl_n), .hit_left(cur_left), .hit_right(cur_right), .hit_bottom(cur_bot_n)
  );

  piece_collide #(.W(W)) u_left (
    .stack(stack_q), .cand(piece_q >> 1),
    .overlap(left_ovl), .hit_left(l_l_n), .hit_right(l_r_n), .hit_bottom(l_b_n)
  );

  piece_collide #(.W(W)) u_right (
    .stack(stack_q), .cand(piece_q << 1),
    .overlap(right_ovl), .hit_left(r_l_n), .hit_right(r_r_n), .hit_bottom(r_b_n)
  );

  // Gravity is judged on the position after this cycle's lateral move.
  piece_collide #(.W(W)) u_pos (
    .stack(stack_q), .cand(pos),
    .overlap(p_ovl_n), .hit_left(p_l_n), .hit_right(p_r_n), .hit_bottom(pos_bottom)
  );

  piece_collide #(.W(W)) u_down (
    .stack(stack_q), .cand(pos << COLS),
    .overlap(down_ovl), .hit_left(d_l_n), .hit_right(d_r_n), .hit_bottom(d_b_n)
  );

  logic unused_flags;
  assign unused_flags = ^{cur_ovl_n, cur_bot_n, l_l_n, l_r_n, l_b_n, r_l_n, r_r_n, r_b_n,
                          p_ovl_n, p_l_n, p_r_n, d_l_n, d_r_n, d_b_n};

  always_comb begin
    pos = piece_q;
    if (move_left && !move_right && !cur_left && !left_ovl)
      pos = piece_q >> 1;
    else if (move_right && !move_left && !cur_right && !right_ovl)
      pos = piece_q << 1;
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q <= GEN;
      stack_q <= '0;
      piece_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stack_q <= stack_d;
      piece_q <= piece_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stack_d = stack_q;
    piece_d = piece_q;
    error_d = error_q;
    case (state_q)
      GEN: begin
        if (spawn) begin
          stack_d = board_in;
          if (|(piece_in & board_in)) begin
            piece_d = '0;
            error_d = 1'b1;
            state_d = OVER;
          end else begin
            piece_d = piece_in;
            state_d = FALL;
          end
        end
      end
      FALL: begin
        piece_d = pos;
        if (tick) begin
          if (pos_bottom || down_ovl) state_d = LOCK;
          else                        piece_d = pos << COLS;
        end
      end
      LOCK: begin
        stack_d = stack_q | piece_q;
        piece_d = '0;
        state_d = GEN;
      end
      OVER:    state_d = OVER;
      default: state_d = GEN;
    endcase
  end

  assign board_out = stack_q | piece_q;
  assign state     = state_q;
  assign landed    = (state_q == LOCK);
  assign error     = error_q;

endmodule

// File: tb/tb_piece_mover.sv
// Bench for piece_mover: directed scenarios plus randomized play against a cell-level game model.
module tb_piece_mover;

  logic        clka = 1'b0;
  logic        restart = 1'b0;
  logic        spawn = 1'b0;
  logic [31:0] board_in = '0;
  logic [31:0] piece_in = '0;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] board_out;
  logic [2:0]  state;
  logic        landed;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  piece_mover dut (
    .clka(clka), .restart(restart), .spawn(spawn), .board_in(board_in), .piece_in(piece_in),
    .move_left(move_left), .move_right(move_right), .tick(tick),
    .board_out(board_out), .state(state), .landed(landed), .error(error)
  );

  always #5 clka = ~clka;

  // Model: game state as plain values, pieces moved cell by cell on an 8x4 grid.
  logic [31:0] m_stack, m_piece;
  int          m_st;
  logic        m_err;

  function automatic bit shift_ok(input logic [31:0] p, input logic [31:0] s,
                                  input int dr, input int dc, output logic [31:0] np);
    np = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (p[4*r+c]) begin
          if (r + dr > 7 || c + dc < 0 || c + dc > 3) return 1'b0;
          if (s[4*(r+dr)+(c+dc)]) return 1'b0;
          np[4*(r+dr)+(c+dc)] = 1'b1;
        end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_stack = '0; m_piece = '0; m_st = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] p, np;
    case (m_st)
      0: if (spawn) begin
        m_stack = board_in;
        if ((piece_in & board_in) != 0) begin
          m_piece = '0; m_err = 1'b1; m_st = 3;
        end else begin
          m_piece = piece_in; m_st = 1;
        end
      end
      1: begin
        p = m_piece;
        if (move_left != move_right)
          if (shift_ok(p, m_stack, 0, move_left ? -1 : 1, np)) p = np;
        if (tick) begin
          if (shift_ok(p, m_stack, 1, 0, np)) p = np;
          else m_st = 2;
        end
        m_piece = p;
      end
      2: begin
        m_stack = m_stack | m_piece; m_piece = '0; m_st = 0;
      end
      default: ;
    endcase
  endtask

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic clear_inputs();
    spawn = 0; move_left = 0; move_right = 0; tick = 0; board_in = '0; piece_in = '0;
  endtask

  task automatic do_restart();
    clear_inputs();
    restart = 1'b1;
    #2;
    restart = 1'b0;
  endtask

  task automatic test_reset();
    do_restart();
    n_cmp++; if (board_out !== 32'h0) begin n_bad++; $display("FAIL reset_board: got %h want 00000000", board_out); end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (landed !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL reset_flags: landed %b error %b want 0 0", landed, error); end
  endtask

  task automatic test_free_fall();
    do_restart();
    spawn = 1; piece_in = 32'h6; cyc(); spawn = 0;
    n_cmp++; if (board_out !== 32'h6 || state !== 3'd1) begin n_bad++; $display("FAIL ff_spawn: got %h/%0d want 00000006/1", board_out, state); end
    tick = 1; repeat (7) cyc();
    n_cmp++; if (board_out !== 32'h6000_0000) begin n_bad++; $display("FAIL ff_bottom: got %h want 60000000", board_out); end
    cyc(); tick = 0;
    n_cmp++; if (landed !== 1'b1 || state !== 3'd2) begin n_bad++; $display("FAIL ff_lock: landed %b state %0d want 1 2", landed, state); end
    cyc();
    n_cmp++; if (state !== 3'd0 || landed !== 1'b0 || board_out !== 32'h6000_0000) begin n_bad++; $display("FAIL ff_gen: state %0d landed %b board %h want 0 0 60000000", state, landed, board_out); end
  endtask

  task automatic test_stacking();
    do_restart();
    spawn = 1; board_in = 32'h6000_0000; piece_in = 32'h6; cyc(); spawn = 0;
    tick = 1; repeat (6) cyc();
    n_cmp++; if (board_out !== 32'h6600_0000 || state !== 3'd1) begin n_bad++; $display("FAIL stack_fall: got %h/%0d want 66000000/1", board_out, state); end
    cyc(); tick = 0;
    n_cmp++; if (landed !== 1'b1) begin n_bad++; $display("FAIL stack_landed: got %b want 1", landed); end
    cyc();
    n_cmp++; if (board_out !== 32'h6600_0000 || state !== 3'd0) begin n_bad++; $display("FAIL stack_lock: got %h/%0d want 66000000/0", board_out, state); end
  endtask

  task automatic test_walls();
    do_restart();
    spawn = 1; piece_in = 32'h1; cyc(); spawn = 0;
    move_left = 1; cyc(); move_left = 0;
    n_cmp++; if (board_out !== 32'h1) begin n_bad++; $display("FAIL wall_left: got %h want 00000001", board_out); end
    move_right = 1; cyc(); move_right = 0;
    n_cmp++; if (board_out !== 32'h2) begin n_bad++; $display("FAIL move_right: got %h want 00000002", board_out); end
    do_restart();
    spawn = 1; piece_in = 32'hC; cyc(); spawn = 0;
    move_right = 1; cyc();
    n_cmp++; if (board_out !== 32'hC) begin n_bad++; $display("FAIL wall_right: got %h want 0000000c", board_out); end
    move_left = 1; cyc(); move_left = 0; move_right = 0;
    n_cmp++; if (board_out !== 32'hC) begin n_bad++; $display("FAIL both_moves: got %h want 0000000c", board_out); end
  endtask

  task automatic test_move_tick();
    do_restart();
    spawn = 1; piece_in = 32'h6; cyc(); spawn = 0;
    move_right = 1; tick = 1; cyc(); move_right = 0; tick = 0;
    n_cmp++; if (board_out !== 32'hC0) begin n_bad++; $display("FAIL move_tick: got %h want 000000c0", board_out); end
  endtask

  task automatic test_game_over();
    do_restart();
    spawn = 1; board_in = 32'h2; piece_in = 32'h6; cyc();
    n_cmp++; if (state !== 3'd3 || error !== 1'b1 || board_out !== 32'h2) begin n_bad++; $display("FAIL over_enter: state %0d error %b board %h want 3 1 00000002", state, error, board_out); end
    board_in = 32'h0; piece_in = 32'h1; tick = 1; move_right = 1; repeat (3) cyc();
    clear_inputs();
    n_cmp++; if (state !== 3'd3 || error !== 1'b1 || board_out !== 32'h2) begin n_bad++; $display("FAIL over_hold: state %0d error %b board %h want 3 1 00000002", state, error, board_out); end
  endtask

  task automatic test_reset_mid_fall();
    do_restart();
    spawn = 1; piece_in = 32'h6; cyc(); spawn = 0;
    tick = 1; repeat (3) cyc(); tick = 0;
    #2; restart = 1'b1; #1;
    n_cmp++; if (board_out !== 32'h0 || state !== 3'd0 || error !== 1'b0) begin n_bad++; $display("FAIL async_reset: board %h state %0d error %b want 0 0 0", board_out, state, error); end
    restart = 1'b0;
    spawn = 1; piece_in = 32'h3; cyc(); spawn = 0;
    n_cmp++; if (state !== 3'd1 || board_out !== 32'h3) begin n_bad++; $display("FAIL first_spawn: state %0d board %h want 1 00000003", state, board_out); end
  endtask

  task automatic test_random();
    logic [31:0] shapes [8];
    logic [31:0] stk;
    shapes = '{32'h1, 32'h3, 32'h6, 32'hC, 32'h8, 32'h33, 32'h26, 32'h7};
    do_restart();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0 || (m_st == 3 && $urandom_range(0, 4) == 0)) begin
        do_restart();
        model_reset();
      end
      stk = $urandom() & $urandom() & 32'hFFFF_F000;
      if ($urandom_range(0, 7) == 0) stk = stk | (32'h1 << $urandom_range(0, 7));
      board_in   = stk;
      piece_in   = shapes[$urandom_range(0, 7)];
      spawn      = ($urandom_range(0, 2) == 0);
      move_left  = ($urandom_range(0, 2) == 0);
      move_right = ($urandom_range(0, 2) == 0);
      tick       = ($urandom_range(0, 2) == 0);
      model_step();
      cyc();
      n_cmp++; if (board_out !== (m_stack | m_piece)) begin n_bad++; $display("FAIL rnd_board[%0d]: got %h want %h", i, board_out, m_stack | m_piece); end
      n_cmp++; if (state !== 3'(m_st)) begin n_bad++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state, m_st); end
      n_cmp++; if (landed !== (m_st == 2)) begin n_bad++; $display("FAIL rnd_landed[%0d]: got %b want %b", i, landed, m_st == 2); end
      n_cmp++; if (error !== m_err) begin n_bad++; $display("FAIL rnd_error[%0d]: got %b want %b", i, error, m_err); end
    end
    clear_inputs();
  endtask

  initial begin
    #3;
    test_reset();
    test_free_fall();
    test_stacking();
    test_walls();
    test_move_tick();
    test_game_over();
    test_reset_mid_fall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piece_mover.md
PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 SHALL have parameter ROWS, default 8: board height in rows.
REQ-002 SHALL have parameter COLS, default 4: board width in columns; the board is ROWS*COLS = 32 bits.
REQ-003 SHALL have port clka, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port restart, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port spawn, input, 1 bit: request to load a new piece, honoured in GEN only.
REQ-006 SHALL have port board_in, input, 32 bits: settled stack, the post-clear board, sampled on spawn.
REQ-007 SHALL have port piece_in, input, 32 bits: mask of the new piece, sampled on spawn.
REQ-008 SHALL have port move_left and move_right, input, 1 bit each: lateral move requests.
REQ-009 SHALL have port tick, input, 1 bit: gravity step request.
REQ-010 SHALL have port board_out, output, 32 bits: stack | piece, combinational from registers.
REQ-011 SHALL have port state, output, 3 bits: current FSM state.
REQ-012 SHALL have port landed, output, 1 bit: one-cycle pulse when a piece locks.
REQ-013 SHALL have port error, output, 1 bit: sticky game-over flag.

Function
REQ-014 Board geometry SHALL be: row r occupies bits [4r+3:4r]; row 0 is the top (spawn rows); row 7 ([31:28]) is the bottom; column c is bit 4r+c.
REQ-015 "Down" SHALL be piece << 4; "left" SHALL be a per-row >>1 of the piece; "right" SHALL be a per-row <<1 of the piece.
REQ-016 The FSM SHALL use these states: GEN=0, FALL=1, LOCK=2, OVER=3; state SHALL drive the state output directly.
REQ-017 GEN with spawn: if piece_in & board_in != 0, the block SHALL go to OVER, set error=1, and leave the piece register at 0; otherwise it SHALL load stack<=board_in and piece<=piece_in and go to FALL. GEN without spawn SHALL hold.
REQ-018 FALL, lateral: move_left SHALL be blocked if any piece bit is in column 0 or the shifted piece overlaps the stack. move_right SHALL be blocked if any piece bit is in column 3 or the shifted piece overlaps the stack. A blocked move SHALL be a no-op.
REQ-019 FALL, move_left and move_right asserted together: both SHALL be ignored.
REQ-020 FALL, tick: the block SHALL evaluate the post-lateral position in the same cycle. If any piece bit is in row 7, or (pos<<4) & stack != 0, it SHALL go to LOCK without moving; otherwise piece<=pos<<4.
REQ-021 LOCK SHALL last one cycle: stack<=stack|piece, piece<=0, landed=1 for that cycle, then go to GEN.
REQ-022 OVER SHALL be terminal until restart; spawn, move and tick SHALL be ignored there.
REQ-023 spawn outside GEN SHALL be ignored; tick or move outside FALL SHALL be ignored.
REQ-024 Latency: an accepted move or tick SHALL be visible on board_out the cycle after the edge. landed SHALL assert the cycle after the blocking tick.

Reset
REQ-025 restart SHALL asynchronously clear stack=0, piece=0, state=GEN, landed=0, error=0, so board_out=0; this SHALL hold even mid-FALL or in LOCK.
REQ-026 On restart deassertion, the first spawn SHALL be accepted on the next posedge.

Structure
REQ-027 The shared package SHALL hold the state encoding (GEN/FALL/LOCK/OVER), ROWS, COLS, and the column-0, column-3 and row-7 masks (32'h1111_1111, 32'h8888_8888, 32'hF000_0000).
REQ-028 A combinational sub-module piece_collide SHALL be used: inputs stack, candidate piece; outputs overlap, hit_left, hit_right, hit_bottom. It SHALL be instantiated once and muxed per check, or replicated per check.

Verification
REQ-029 Free fall: empty board, spawn piece 32'h0000_0006, 7 ticks -> board_out=32'h6000_0000; 8th tick -> landed pulse, then GEN with board_out=32'h6000_0000.
REQ-030 Stacking: board_in=32'h6000_0000, spawn 32'h0000_0006, 6 ticks -> 32'h6600_0000; 7th tick -> lock, stack=32'h6600_0000.
REQ-031 Walls: spawn 32'h0000_0001, move_left -> unchanged; move_right -> 32'h0000_0002; piece 32'h0000_000C with move_right -> unchanged; both moves together -> unchanged.
REQ-032 Move+tick same cycle: piece 32'h0000_0006 on empty board, move_right with tick -> 32'h0000_00C0.
REQ-033 Game over: board_in=32'h0000_0002, spawn 32'h0000_0006 -> state=3, error=1, board_out=32'h0000_0002; later spawns ignored.
REQ-034 Reset mid-fall: after 3 ticks assert restart asynchronously between edges -> board_out=0, state=0, error=0 immediately.
